// File: rtl/clk_divider_prog.sv
// rtl/clk_divider_prog.sv - runtime-programmable 50% duty clock divider with tick and glitch-free reload
`timescale 1ns/1ps
module clk_divider_prog #(
  parameter int unsigned     CNT_WIDTH    = 32,
  parameter longint unsigned DEFAULT_HALF = 64'd9999999
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] half_period_in,
  input  logic                 load,
  output logic                 load_ack,
  output logic                 divided_clk,
  output logic                 tick,
  output logic [CNT_WIDTH-1:0] active_half
);

  if ((CNT_WIDTH < 64) && ((DEFAULT_HALF >> CNT_WIDTH) != 64'd0)) begin : g_default_half_check
    $error("DEFAULT_HALF does not fit in CNT_WIDTH bits");
  end

  localparam logic [CNT_WIDTH-1:0] RESET_HALF = CNT_WIDTH'(DEFAULT_HALF);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] active_q, active_d;
  logic [CNT_WIDTH-1:0] pend_half_q, pend_half_d;
  logic                 pend_q, pend_d;
  logic                 div_q, div_d;
  logic                 tick_q, tick_d;
  logic                 ack_q, ack_d;
  logic                 terminal;

  assign terminal = (cnt_q == active_q);

  always_comb begin
    cnt_d       = cnt_q;
    active_d    = active_q;
    pend_half_d = pend_half_q;
    pend_d      = pend_q;
    div_d       = div_q;
    tick_d      = 1'b0;
    ack_d       = 1'b0;

    if (en) begin
      if (terminal) begin
        cnt_d  = '0;
        div_d  = ~div_q;
        tick_d = ~div_q;
        if (pend_q) begin
          active_d = pend_half_q;
          pend_d   = 1'b0;
          ack_d    = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end else if (pend_q) begin
      // Held divider: nothing to protect, so apply at once and restart the half.
      active_d = pend_half_q;
      pend_d   = 1'b0;
      cnt_d    = '0;
      ack_d    = 1'b1;
    end

    // A load on an apply edge re-arms pending with the newer value.
    if (load) begin
      pend_half_d = half_period_in;
      pend_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      active_q    <= RESET_HALF;
      pend_half_q <= '0;
      pend_q      <= 1'b0;
      div_q       <= 1'b0;
      tick_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pend_half_q <= pend_half_d;
      pend_q      <= pend_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      ack_q       <= ack_d;
    end
  end

  assign load_ack    = ack_q;
  assign divided_clk = div_q;
  assign tick        = tick_q;
  assign active_half = active_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// tb/tb_clk_divider_prog.sv - directed scoreboard bench for clk_divider_prog
`timescale 1ns/1ps
module tb_clk_divider_prog;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] half_period_in;
  logic         load;
  logic         load_ack;
  logic         divided_clk;
  logic         tick;
  logic [W-1:0] active_half;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic         div;
    logic         tck;
    logic         ack;
    logic [W-1:0] act;
  } exp_t;

  exp_t sb[$];

  logic [W-1:0] m_cnt, m_act, m_ph;
  logic         m_div, m_pend;

  clk_divider_prog #(.CNT_WIDTH(W), .DEFAULT_HALF(64'd3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .half_period_in (half_period_in),
    .load           (load),
    .load_ack       (load_ack),
    .divided_clk    (divided_clk),
    .tick           (tick),
    .active_half    (active_half)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = '0; m_act = W'(3); m_ph = '0; m_div = 1'b0; m_pend = 1'b0;
  endtask

  // Drive one cycle of stimulus, push the expected post-edge outputs, then compare.
  task automatic step(input logic e, input logic ld, input logic [W-1:0] v);
    exp_t x;
    x.tck = 1'b0;
    x.ack = 1'b0;
    en = e; load = ld; half_period_in = v;
    if (e) begin
      if (m_cnt == m_act) begin
        m_cnt = '0;
        m_div = ~m_div;
        x.tck = m_div;
        if (m_pend) begin
          m_act = m_ph; m_pend = 1'b0; x.ack = 1'b1;
        end
      end else begin
        m_cnt = m_cnt + 1'b1;
      end
    end else if (m_pend) begin
      m_act = m_ph; m_pend = 1'b0; m_cnt = '0; x.ack = 1'b1;
    end
    if (ld) begin
      m_ph = v; m_pend = 1'b1;
    end
    x.div = m_div;
    x.act = m_act;
    sb.push_back(x);
    @(posedge clk);
    #1;
    load = 1'b0;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check("divided_clk", 32'(divided_clk), 32'(x.div));
      check("tick", 32'(tick), 32'(x.tck));
      check("load_ack", 32'(load_ack), 32'(x.ack));
      check("active_half", 32'(active_half), 32'(x.act));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
  endtask

  task automatic run_until_cnt(input logic [W-1:0] c);
    int guard = 0;
    while (m_cnt != c && guard < 64) begin
      step(1'b1, 1'b0, '0);
      guard++;
    end
    check("cnt_reach_bound", 32'(guard < 64), 32'd1);
  endtask

  task automatic check_restart(input string tag);
    logic [7:0] exp_div;
    logic [7:0] exp_tick;
    exp_div  = 8'b0111_1000;
    exp_tick = 8'b0000_1000;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, '0);
      check({tag, "_div"}, 32'(divided_clk), 32'(exp_div[i]));
      check({tag, "_tick"}, 32'(tick), 32'(exp_tick[i]));
    end
  endtask

  initial begin
    int acks;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; half_period_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_div", 32'(divided_clk), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_ack", 32'(load_ack), 32'd0);
    check("rst_active", 32'(active_half), 32'd3);
    rst_n = 1'b1;

    // 1: default H=3, rise on edge 4, fall on edge 8
    check_restart("s1");
    run(8);

    // 2: H=0 gives clk/2
    step(1'b1, 1'b1, W'(0));
    run(12);

    // 3: back to H=3, then load 5 at cnt=1
    step(1'b1, 1'b1, W'(3));
    run(10);
    run_until_cnt(W'(1));
    step(1'b1, 1'b1, W'(5));
    run(20);
    check("s3_active", 32'(active_half), 32'd5);

    // 4: two loads before terminal, only the latest applies with one ack
    run_until_cnt(W'(0));
    step(1'b1, 1'b1, W'(5));
    step(1'b1, 1'b1, W'(9));
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, '0);
      if (load_ack) acks++;
    end
    check("s4_one_ack", 32'(acks), 32'd1);
    check("s4_active", 32'(active_half), 32'd9);
    run_until_cnt(W'(9));
    step(1'b1, 1'b1, W'(2));
    check("s4_term_load_not_applied", 32'(active_half), 32'd9);
    run(25);
    check("s4_term_load_applied", 32'(active_half), 32'd2);

    // 5: H=3, hold at cnt=2, then load while held
    step(1'b1, 1'b1, W'(3));
    run(10);
    run_until_cnt(W'(2));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("s5_tick_after_2", 32'(tick | (divided_clk ^ m_div)), 32'(m_div));
    run(6);
    step(1'b0, 1'b1, W'(4));
    step(1'b0, 1'b0, '0);
    check("s5_held_ack", 32'(load_ack), 32'd1);
    check("s5_held_active", 32'(active_half), 32'd4);
    run(12);

    // 6: async reset while divided_clk=1 with a load pending
    begin
      int guard = 0;
      while (!(m_div && m_cnt == 0) && guard < 64) begin
        step(1'b1, 1'b0, '0);
        guard++;
      end
      check("s6_reach_bound", 32'(guard < 64), 32'd1);
    end
    step(1'b1, 1'b1, W'(7));
    check("s6_div_high", 32'(divided_clk), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("s6_async_div", 32'(divided_clk), 32'd0);
    check("s6_async_tick", 32'(tick), 32'd0);
    check("s6_async_ack", 32'(load_ack), 32'd0);
    check("s6_async_active", 32'(active_half), 32'd3);
    model_reset();
    en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_restart("s6");
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, '0);
      if (load_ack) acks++;
    end
    check("s6_no_ack", 32'(acks), 32'd0);
    check("s6_active_default", 32'(active_half), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
Runtime-programmable, parametrised clock divider. It generates a 50%-duty divided clock plus a one-cycle enable tick from the 100 MHz system clock. It replaces the fixed-ratio divider instances: a single instance covers every blink, scan and debounce rate. The divide ratio can be reloaded glitch-free while the divider runs. Downstream logic should prefer tick as a clock enable and use divided_clk only for external or visual outputs.

Parameters:
CNT_WIDTH, 32, width of the half-period counter and the programmed value.
DEFAULT_HALF, 9999999, half-period terminal count loaded at reset (5 Hz at 100 MHz). Must be < 2^CNT_WIDTH; elaboration fails otherwise.

Ports:
clk  input  1  system clock, 100 MHz, rising edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  count enable; when low, counter and outputs hold
half_period_in  input  CNT_WIDTH  new half-period terminal count H
load  input  1  one-cycle strobe; captures half_period_in
load_ack  output  1  one-cycle pulse when a loaded value becomes active
divided_clk  output  1  divided clock, period 2*(H+1) clk cycles
tick  output  1  one-cycle pulse on the cycle divided_clk rises
active_half  output  CNT_WIDTH  terminal count currently in use

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed) sets the following: cnt=0, divided_clk=0, tick=0, load_ack=0, active_half=DEFAULT_HALF, pending=0.
- Internal state: cnt (CNT_WIDTH), pending_half (CNT_WIDTH), pending flag. All outputs are registered.
- Counting, when en=1:
  - If cnt==active_half: cnt<=0 and divided_clk toggles. This is the "terminal cycle".
  - Otherwise cnt<=cnt+1.
- Output frequency is f_clk/(2*(H+1)). H=0 gives clk/2. The counter never exceeds active_half.
- tick is asserted on the same edge that drives divided_clk 0->1. It is high for exactly one cycle per output period and is 0 at all other times, including while en=0.
- Hold, when en=0: cnt, divided_clk and active_half are frozen and tick=0. Counting resumes with the remaining count when en returns to 1; no cycles are lost or added.
- Load handshake:
  - On load=1, pending_half<=half_period_in and pending<=1.
  - A new load while pending=1 overwrites pending_half (latest wins). Only one load_ack is produced.
- Apply, when en=1:
  - The pending value is applied on the next terminal cycle: active_half<=pending_half and pending<=0. cnt goes to 0 as usual.
  - The half-period in progress always completes with the old H, so no truncated pulses occur.
  - A load in the same cycle as a terminal cycle is not applied on that edge. It is applied at the following terminal cycle.
- Apply, when en=0: a pending value is applied on the next clock edge. cnt<=0 and divided_clk holds its level.
- load_ack is high for the single cycle following the apply edge.
- half_period_in=0 is legal. Any value up to 2^CNT_WIDTH-1 is legal. Arithmetic is unsigned, and the counter never wraps because the compare is ==.
- After reset release with en=1, the first toggle occurs on rising edge number DEFAULT_HALF+1.

Test Plan:
1. DEFAULT_HALF=3, en=1 after reset -> divided_clk rises on edge 4, falls on edge 8, period 8 cycles. tick high once every 8 cycles, on the rise edges.
2. Load H=0 -> after the current half completes, divided_clk toggles every cycle (period 2) and tick pulses every 2 cycles.
3. H=3 active, load H=5 at cnt=1 -> the current half still lasts 4 cycles. load_ack pulses the cycle after that toggle. Subsequent halves last 6 cycles and active_half reads 5.
4. Load 5, then load 9 before the terminal cycle -> only 9 is applied and exactly one load_ack pulse occurs. Load asserted exactly on a terminal cycle -> applied one half-period later.
5. H=3, drop en for 10 cycles at cnt=2 -> cnt, divided_clk and tick are frozen with tick=0. After re-enable, the toggle occurs 2 cycles later. A load during en=0 applies on the next edge with cnt=0 and is acknowledged.
6. Assert rst_n low between clock edges while divided_clk=1 with a load pending -> divided_clk, tick and load_ack go to 0 immediately. active_half=DEFAULT_HALF, no ack is issued for the pending value, and restart timing matches scenario 1.
